// File: rtl/result_reader.sv
// Snapshots a packed register file on start and streams its elements (element 0 first) over valid/ready; first beat 1 cycle after start, holds under backpressure.
// `define RESULT_READER_SKIP_ZERO_EN to present only non-zero elements (all-zero capture goes straight to the done pulse).
module result_reader #(
  parameter int ELEM_W   = 6,
  parameter int NUM_ELEM = 8,
  parameter int IDX_W    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ELEM_W*NUM_ELEM-1:0] contents_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [ELEM_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

  state_t                     state;
  logic [ELEM_W*NUM_ELEM-1:0] snap;
  logic [NUM_ELEM-1:0]        send_mask;
  logic [NUM_ELEM-1:0]        cap_mask;
  logic [IDX_W-1:0]           cap_first;
  logic                       cap_last;
  logic                       cap_any;
  logic [IDX_W:0]             after_idx;
  logic [IDX_W-1:0]           nxt_idx;
  logic                       nxt_last;

  function automatic logic [IDX_W-1:0] first_from(input logic [NUM_ELEM-1:0] m,
                                                  input logic [IDX_W:0]      from);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = NUM_ELEM - 1; k >= 0; k--)
      if (m[k] && (k >= int'(from))) r = IDX_W'(k);
    return r;
  endfunction

  function automatic logic none_above(input logic [NUM_ELEM-1:0] m,
                                      input logic [IDX_W-1:0]    idx);
    logic r;
    r = 1'b1;
    for (int k = 0; k < NUM_ELEM; k++)
      if (m[k] && (k > int'(idx))) r = 1'b0;
    return r;
  endfunction

  function automatic logic [ELEM_W-1:0] elem(input logic [ELEM_W*NUM_ELEM-1:0] v,
                                             input logic [IDX_W-1:0]           i);
    return v[int'(i)*ELEM_W +: ELEM_W];
  endfunction

  // The mask selects which elements get presented; the walk logic is the same either way.
  always_comb begin
    cap_mask = '1;
`ifdef RESULT_READER_SKIP_ZERO_EN
    for (int k = 0; k < NUM_ELEM; k++)
      cap_mask[k] = |contents_in[k*ELEM_W +: ELEM_W];
`endif
  end

  assign cap_any   = |cap_mask;
  assign cap_first = first_from(cap_mask, '0);
  assign cap_last  = none_above(cap_mask, cap_first);
  assign after_idx = {1'b0, out_index} + 1'b1;
  assign nxt_idx   = first_from(send_mask, after_idx);
  assign nxt_last  = none_above(send_mask, nxt_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      snap      <= '0;
      send_mask <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap      <= contents_in;
            send_mask <= cap_mask;
            out_index <= cap_first;
            out_data  <= elem(contents_in, cap_first);
            busy      <= 1'b1;
            if (cap_any) begin
              state     <= SEND;
              out_valid <= 1'b1;
              out_last  <= cap_last;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= FINISH;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_index <= nxt_idx;
              out_data  <= elem(snap, nxt_idx);
              out_last  <= nxt_last;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: a queue-based beat model checked every cycle, plus literal spot checks.
module tb_result_reader;

  localparam int ELEM_W   = 6;
  localparam int NUM_ELEM = 8;
  localparam int IDX_W    = 3;

  logic                       clk;
  logic                       reset;
  logic                       start;
  logic [ELEM_W*NUM_ELEM-1:0] contents_in;
  logic                       out_ready;
  logic                       out_valid;
  logic [ELEM_W-1:0]          out_data;
  logic [IDX_W-1:0]           out_index;
  logic                       out_last;
  logic                       busy;
  logic                       done;

  result_reader #(.ELEM_W(ELEM_W), .NUM_ELEM(NUM_ELEM), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .contents_in(contents_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int beat_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a stream is the list of beats the snapshot must produce; phase 0 idle, 1 streaming, 2 done cycle.
  typedef struct { int idx; int dat; } beat_t;
  beat_t q[$];
  int    phase;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      phase = 0;
    end else begin
      case (phase)
        0: if (start) begin
          for (int k = 0; k < NUM_ELEM; k++) begin
            beat_t b;
            b.idx = k;
            b.dat = int'(contents_in[k*ELEM_W +: ELEM_W]);
`ifdef RESULT_READER_SKIP_ZERO_EN
            if (b.dat != 0) q.push_back(b);
`else
            q.push_back(b);
`endif
          end
          phase = (q.size() == 0) ? 2 : 1;
        end
        1: if (out_ready) begin
          void'(q.pop_front());
          beat_cnt++;
          if (q.size() == 0) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (done) done_cnt++;
      chk("m_valid", out_valid, phase == 1);
      chk("m_busy", busy, phase != 0);
      chk("m_done", done, phase == 2);
      if (phase == 1 && q.size() > 0) begin
        chk("m_index", out_index, q[0].idx);
        chk("m_data", out_data, q[0].dat);
        chk("m_last", out_last, q.size() == 1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_seq();
    for (int k = 0; k < NUM_ELEM; k++) contents_in[k*ELEM_W +: ELEM_W] = ELEM_W'(k + 1);
  endtask

  task automatic wait_done(input string name, input int bound);
    int i;
    i = 0;
    while (done !== 1'b1 && i < bound) begin
      cyc(1);
      i++;
    end
    if (done !== 1'b1) chk({name, "_timeout"}, 0, 1);
  endtask

  logic [3:0] rpat;
  int d0, b0;

  initial begin
    reset = 1'b0; start = 1'b0; contents_in = '0; out_ready = 1'b0;
    rpat = 4'b1001;
    cyc(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    reset = 1'b1;
    cyc(2);
    chk("idle_busy", busy, 0);

    // Back-to-back stream of 1..8
    load_seq(); out_ready = 1'b1; start = 1'b1;
    cyc(1); start = 1'b0;
    chk("t2_first_valid", out_valid, 1);
    chk("t2_first_idx", out_index, 0);
    chk("t2_first_data", out_data, 1);
    cyc(7);
    chk("t2_last_idx", out_index, 7);
    chk("t2_last_data", out_data, 8);
    chk("t2_last_flag", out_last, 1);
    cyc(1);
    chk("t2_done", done, 1);
    chk("t2_valid_drop", out_valid, 0);
    cyc(1);
    chk("t2_idle", busy, 0);

    // Stalled stream with ready pattern 1,0,0,1
    b0 = beat_cnt;
    start = 1'b1; out_ready = 1'b1;
    cyc(1); start = 1'b0;
    for (int i = 0; i < 100 && done !== 1'b1; i++) begin
      out_ready = rpat[i % 4];
      cyc(1);
    end
    chk("t3_done", done, 1);
    chk("t3_beats", beat_cnt - b0, 8);
    out_ready = 1'b1;
    cyc(2);

    // Snapshot isolation and ignored start during SEND
    d0 = done_cnt;
    load_seq(); start = 1'b1;
    cyc(1); start = 1'b0;
    contents_in = {NUM_ELEM{6'h3F}};
    cyc(2);
    chk("t4_idx2", out_index, 2);
    chk("t4_data2", out_data, 3);
    start = 1'b1;
    cyc(1); start = 1'b0;
    wait_done("t4", 20);
    cyc(4);
    chk("t4_single_done", done_cnt - d0, 1);
    chk("t4_idle", busy, 0);

    // start held high re-captures on the first IDLE cycle after FINISH
    load_seq(); start = 1'b1;
    cyc(1);
    wait_done("t5a", 20);
    cyc(1);
    chk("t5_idle_gap_busy", busy, 0);
    chk("t5_idle_gap_valid", out_valid, 0);
    cyc(1);
    chk("t5_recapture_valid", out_valid, 1);
    chk("t5_recapture_idx", out_index, 0);
    start = 1'b0;
    wait_done("t5b", 20);
    cyc(2);

    // Sparse contents {2:5, 5:9}
    contents_in = '0;
    contents_in[2*ELEM_W +: ELEM_W] = 6'd5;
    contents_in[5*ELEM_W +: ELEM_W] = 6'd9;
    start = 1'b1;
    cyc(1); start = 1'b0;
`ifdef RESULT_READER_SKIP_ZERO_EN
    chk("t6_b0_idx", out_index, 2);
    chk("t6_b0_data", out_data, 5);
    chk("t6_b0_last", out_last, 0);
    cyc(1);
    chk("t6_b1_idx", out_index, 5);
    chk("t6_b1_data", out_data, 9);
    chk("t6_b1_last", out_last, 1);
    cyc(1);
    chk("t6_done", done, 1);
    cyc(2);
    contents_in = '0; start = 1'b1;
    b0 = beat_cnt;
    cyc(1); start = 1'b0;
    chk("t6_zero_done", done, 1);
    chk("t6_zero_valid", out_valid, 0);
    cyc(1);
    chk("t6_zero_beats", beat_cnt - b0, 0);
    chk("t6_zero_idle", busy, 0);
`else
    chk("t6_b0_idx", out_index, 0);
    chk("t6_b0_data", out_data, 0);
    cyc(2);
    chk("t6_b2_data", out_data, 5);
    wait_done("t6", 20);
    cyc(2);
`endif

    // Reset mid-stream at beat 3
    d0 = done_cnt;
    load_seq(); start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(3);
    chk("t1_beat3_idx", out_index, 3);
    reset = 1'b0;
    #1;
    chk("t1_rst_valid", out_valid, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_data", out_data, 0);
    chk("t1_rst_index", out_index, 0);
    chk("t1_rst_last", out_last, 0);
    cyc(2);
    reset = 1'b1;
    cyc(6);
    chk("t1_no_done", done_cnt - d0, 0);
    chk("t1_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/result_reader.md
Name: result_reader

Overview:
Readout side of the product register file. On `start` it snapshots the packed 48-bit register contents. It then streams the eight 6-bit elements, element 0 first, over a valid/ready handshake to downstream logic such as a display or serial sink. It signals the final beat and pulses `done` when the streaming is finished.

Parameters:
- ELEM_W, 6, width of one element in bits.
- NUM_ELEM, 8, number of elements. Must be a power of two, ≥ 2.
- IDX_W, 3, index width, equal to log2(NUM_ELEM).

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  request to capture and stream; sampled only in IDLE.
- contents_in  in  ELEM_W*NUM_ELEM  packed registers; element k occupies bits [k*ELEM_W+ELEM_W-1 : k*ELEM_W].
- out_ready  in  1  sink can accept a beat.
- out_valid  out  1  `out_data`, `out_index` and `out_last` are valid.
- out_data  out  ELEM_W  element value.
- out_index  out  IDX_W  element number of the current beat.
- out_last  out  1  current beat is the final beat.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - Snapshot register cleared to 0.
  - `out_valid`, `out_last`, `busy`, `done` = 0.
  - `out_data`=0, `out_index`=0.
  - Reset asserted mid-stream abandons the stream immediately; no `done` is produced.
- States: IDLE, SEND, FINISH.
- IDLE:
  - On a rising edge with start=1: `contents_in` is latched into the snapshot, `out_index` is set to the first element, and state goes to SEND.
  - `out_valid` rises in the cycle after `start` is sampled (1-cycle latency).
- SEND:
  - `out_valid`=1.
  - `out_data` = snapshot element[`out_index`].
  - `out_last`=1 when `out_index` is the final element to be sent.
  - A beat transfers on a rising edge with out_valid=1 and out_ready=1.
  - On a non-final transfer, `out_index` advances to the next element.
  - On the final transfer, state goes to FINISH and `out_valid` drops.
- Stall: while out_valid=1 and out_ready=0, `out_data`, `out_index` and `out_last` hold stable. There is no timeout.
- out_ready=1 continuously gives back-to-back beats, one per cycle: 8 beats in 8 consecutive cycles.
- FINISH: `done`=1 and `busy`=1 for exactly one cycle, then IDLE unconditionally.
- `start` while `busy`=1 is ignored and is not queued.
- `start` held high continuously triggers a new capture on the first IDLE cycle after FINISH.
- The snapshot isolates the stream: changes on `contents_in` after capture do not affect beats in flight.
- `out_index` does not wrap during a stream. It returns to 0 only on the next capture or on reset.
- `out_data`/`out_index` outside SEND are don't-care for the sink. They must not be X after reset.

Optional Feature:
- Macro: RESULT_READER_SKIP_ZERO_EN.
- Defined:
  - Elements whose snapshot value is 0 are skipped; only non-zero elements are presented, in ascending index order.
  - `out_index` carries the true element number.
  - `out_last` marks the highest-indexed non-zero element.
  - Capture computes a non-zero mask and starts at the lowest set bit.
  - If all elements are zero, capture goes directly IDLE→FINISH. No beat is sent, and `done` pulses in the cycle after `start`.
- Undefined: all NUM_ELEM elements are sent regardless of value.

Test Plan:
1. Reset asserted, then released → `busy`, `out_valid`, `done` = 0 and `out_data`=0. Assert reset mid-stream at beat 3 → outputs go to 0 immediately, and no `done` pulse follows.
2. contents_in with element k = k+1 (values 1..8), start for 1 cycle, out_ready=1 → `out_valid` high from cycle+1. Beats (index,data) run (0,1)…(7,8) on consecutive cycles, `out_last` only on index 7, `done` pulses once the next cycle.
3. Same stimulus with out_ready toggled 1,0,0,1,… → every beat is seen exactly once, and data/index are stable during stalls.
4. After capture, change contents_in to all 6'h3F and pulse start again during SEND → the stream still delivers the captured values 1..8, and the second start is ignored (a single `done`).
5. start held high → second capture begins on the first IDLE cycle after FINISH, and `out_valid` rises 1 cycle later.
6. With RESULT_READER_SKIP_ZERO_EN, elements {0:0, 2:5, 5:9, others 0} → beats (2,5) then (5,9) with `out_last` on (5,9). All-zero contents → no beats, and `done` pulses 1 cycle after start.
